// File: rtl/xy_fsm_array.sv
// xy_fsm_array: NUM_CH independent x/y Moore sequence machines. Each channel has an
// advance enable, a synchronous clear and a timed escape from the trap states S1/S9.
// A shared saturating counter tallies S9 entries across all channels.

// One channel: state register, hold timer, Moore decode and S9-entry strobe.
module xy_fsm_ch #(
  parameter int HOLD_CYCLES = 8,
  parameter int HOLD_W      = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       clr,
  input  logic       x,
  input  logic       y,
  output logic [2:0] z,
  output logic [2:0] state_o,
  output logic       trap,
  output logic       entry
);
  typedef enum logic [2:0] {
    S7  = 3'd0,
    S10 = 3'd1,
    S5  = 3'd2,
    S6  = 3'd3,
    S1  = 3'd4,
    S9  = 3'd5
  } state_t;

  localparam int HOLD_LAST = (HOLD_CYCLES > 0) ? HOLD_CYCLES - 1 : 0;

  state_t            state, nxt;
  logic [HOLD_W-1:0] timer, timer_nxt;
  logic              timeout;

  // State and hold-timer registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S7;
      timer <= '0;
    end else begin
      state <= nxt;
      timer <= timer_nxt;
    end
  end

  // Next state (clr > illegal recovery > hold timeout > en-gated step), timer, outputs.
  always_comb begin
    nxt       = state;
    trap      = (state == S1) || (state == S9);
    timeout   = (HOLD_CYCLES > 0) && trap && (timer == HOLD_W'(HOLD_LAST));
    timer_nxt = trap ? timer + 1'b1 : '0;
    z         = 3'b000;

    if (clr) begin
      nxt       = S7;
      timer_nxt = '0;
    end else if (timeout) begin
      nxt = S7;
    end else begin
      case (state)
        S7:      if (en && y) nxt = x ? S9 : S10;
        S10:     if (en) nxt = S5;
        S5:      if (en) nxt = y ? S1 : (x ? S9 : S6);
        S6:      if (en) nxt = S1;
        S1:      nxt = S1;
        S9:      nxt = S9;
        default: nxt = S7;   // codes 6/7 recover regardless of en
      endcase
    end

    case (state)
      S1:      z = 3'b101;
      S5:      z = 3'b001;
      S6:      z = 3'b010;
      S9:      z = 3'b001;
      default: z = 3'b000;
    endcase

    state_o = state;
    entry   = (nxt == S9) && (state != S9);
  end
endmodule

// Top: channel array plus the saturating S9-entry counter.
module xy_fsm_array #(
  parameter int NUM_CH      = 4,
  parameter int HOLD_CYCLES = 8,
  parameter int HOLD_W      = 8,
  parameter int CNT_W       = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_CH-1:0]     en,
  input  logic [NUM_CH-1:0]     clr,
  input  logic [NUM_CH-1:0]     x,
  input  logic [NUM_CH-1:0]     y,
  output logic [3*NUM_CH-1:0]   z,
  output logic [3*NUM_CH-1:0]   state_o,
  output logic [NUM_CH-1:0]     trap,
  output logic [CNT_W-1:0]      s9_cnt
);
  localparam int IW = $clog2(NUM_CH + 1);
  localparam int SW = CNT_W + IW;

  logic [NUM_CH-1:0] entry;
  logic [IW-1:0]     inc;
  logic [SW-1:0]     sum;
  logic [CNT_W-1:0]  cnt_nxt;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    xy_fsm_ch #(
      .HOLD_CYCLES(HOLD_CYCLES),
      .HOLD_W     (HOLD_W)
    ) u_ch (
      .clk    (clk),
      .rst    (rst),
      .en     (en[i]),
      .clr    (clr[i]),
      .x      (x[i]),
      .y      (y[i]),
      .z      (z[3*i +: 3]),
      .state_o(state_o[3*i +: 3]),
      .trap   (trap[i]),
      .entry  (entry[i])
    );
  end

  // Count this cycle's S9 entries and add with saturation at all-ones.
  always_comb begin
    inc = '0;
    for (int i = 0; i < NUM_CH; i++) inc = inc + IW'(entry[i]);
    sum = SW'(s9_cnt) + SW'(inc);
    if (sum > SW'({CNT_W{1'b1}})) cnt_nxt = {CNT_W{1'b1}};
    else                          cnt_nxt = sum[CNT_W-1:0];
  end

  // S9-entry counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) s9_cnt <= '0;
    else     s9_cnt <= cnt_nxt;
  end
endmodule

// File: tb/tb_xy_fsm_array.sv
// Bench for xy_fsm_array: two instances (timed escape with wide counter, and absorbing
// traps with a 3-bit counter) share stimulus and are compared every cycle against a
// behavioural model, plus directed literal checks of the spec scenarios.
module tb_xy_fsm_array;
  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] en = '0, clr = '0, x = '0, y = '0;
  logic [3*N-1:0] z_a, st_a, z_b, st_b;
  logic [N-1:0]   trap_a, trap_b;
  logic [15:0]    cnt_a;
  logic [2:0]     cnt_b;

  int checks = 0;
  int errors = 0;

  // Model: index 0 = instance a, 1 = instance b. State numbers follow the spec encoding.
  int hold[2]   = '{8, 0};
  int cmax[2]   = '{65535, 7};
  int mst[2][N];
  int mtm[2][N];
  int mcnt[2];

  xy_fsm_array dut_a (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .x(x), .y(y),
    .z(z_a), .state_o(st_a), .trap(trap_a), .s9_cnt(cnt_a)
  );

  xy_fsm_array #(.HOLD_CYCLES(0), .CNT_W(3)) dut_b (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .x(x), .y(y),
    .z(z_b), .state_o(st_b), .trap(trap_b), .s9_cnt(cnt_b)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int zof(input int s);
    case (s)
      4: return 5;
      2: return 1;
      3: return 2;
      5: return 1;
      default: return 0;
    endcase
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      mcnt[k] = 0;
      for (int c = 0; c < N; c++) begin
        mst[k][c] = 0;
        mtm[k][c] = 0;
      end
    end
  endtask

  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      int e;
      e = 0;
      for (int c = 0; c < N; c++) begin
        int s, t, ns;
        bit tr;
        s  = mst[k][c];
        t  = mtm[k][c];
        tr = (s == 4) || (s == 5);
        if (clr[c])                               ns = 0;
        else if (s > 5)                           ns = 0;
        else if (tr && hold[k] > 0 && t == hold[k] - 1) ns = 0;
        else if (!en[c])                          ns = s;
        else begin
          case (s)
            0: ns = y[c] ? (x[c] ? 5 : 1) : 0;
            1: ns = 2;
            2: ns = y[c] ? 4 : (x[c] ? 5 : 3);
            3: ns = 4;
            default: ns = s;
          endcase
        end
        if (ns == 5 && s != 5) e++;
        mtm[k][c] = clr[c] ? 0 : (tr ? t + 1 : 0);
        mst[k][c] = ns;
      end
      mcnt[k] = (mcnt[k] + e > cmax[k]) ? cmax[k] : mcnt[k] + e;
    end
  endtask

  // One clock: model advances on the same edge as the DUTs, inputs may change 1 ns later.
  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      if (!rst) model_step();
      #1;
    end
  endtask

  // Per-cycle comparison of both instances against the model, away from the active edge.
  always @(negedge clk) begin
    if (!rst) begin
      logic [3*N-1:0] es[2], ez[2];
      logic [N-1:0]   et[2];
      for (int k = 0; k < 2; k++)
        for (int c = 0; c < N; c++) begin
          es[k][3*c +: 3] = 3'(mst[k][c]);
          ez[k][3*c +: 3] = 3'(zof(mst[k][c]));
          et[k][c]        = (mst[k][c] == 4) || (mst[k][c] == 5);
        end
      chk("a.state_o", st_a, es[0]);
      chk("a.z", z_a, ez[0]);
      chk("a.trap", trap_a, et[0]);
      chk("a.s9_cnt", cnt_a, mcnt[0]);
      chk("b.state_o", st_b, es[1]);
      chk("b.z", z_b, ez[1]);
      chk("b.trap", trap_b, et[1]);
      chk("b.s9_cnt", cnt_b, mcnt[1]);
    end
  end

  initial begin
    model_reset();
    // 1: reset, then idle with en high
    #12;
    chk("rst.state_o", st_a, 0);
    chk("rst.z", z_a, 0);
    rst = 1'b0;
    en  = '1;
    cyc(5);
    chk("idle.state_o", st_a, 0);
    chk("idle.z", z_a, 0);
    chk("idle.trap", trap_a, 0);
    chk("idle.s9_cnt", cnt_a, 0);

    // 2: ch0 S7 -> S10 -> S5 -> S1, then timed escape after 8 trap cycles
    y = 4'b0001; x = '0;
    cyc();
    chk("t2.s10", st_a[2:0], 1);
    chk("t2.z_s10", z_a[2:0], 0);
    cyc();
    chk("t2.z_s5", z_a[2:0], 1);
    cyc();
    chk("t2.z_s1", z_a[2:0], 5);
    chk("t2.trap", trap_a[0], 1);
    y = '0;
    cyc(7);
    chk("t2.trap_7", trap_a[0], 1);
    cyc();
    chk("t2.trap_8", trap_a[0], 0);
    chk("t2.back_s7", st_a[2:0], 0);
    clr = '1; cyc(); clr = '0;

    // 3: ch1 S10 -> S5 -> S9, one entry counted, escape leaves count alone
    y = 4'b0010; cyc();
    y = '0; x = 4'b0010; cyc(2);
    chk("t3.s9", st_a[5:3], 5);
    chk("t3.z", z_a[5:3], 1);
    chk("t3.cnt", cnt_a, 1);
    x = '0;
    cyc(8);
    chk("t3.back_s7", st_a[5:3], 0);
    chk("t3.cnt_keep", cnt_a, 1);
    clr = '1; cyc(); clr = '0;

    // 4: all channels into S9 at once; narrow counter saturates at 7
    x = '1; y = '1;
    cyc();
    chk("t4.trap_all", trap_a, 4'hf);
    chk("t4.cnt_a", cnt_a, 5);
    chk("t4.cnt_b", cnt_b, 5);
    clr = '1; cyc(); clr = '0;
    cyc();
    chk("t4.cnt_a2", cnt_a, 9);
    chk("t4.cnt_b_sat", cnt_b, 7);
    clr = '1; cyc(); clr = '0;
    cyc();
    chk("t4.cnt_b_nowrap", cnt_b, 7);
    clr = '1; cyc(); clr = '0;
    x = '0; y = '0;

    // 5: ch2 parked in S5 with en low, then clr wins over y&x
    y = 4'b0100; cyc(2);
    en = 4'b1011; x = 4'b0100; y = 4'b0100;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("t5.hold_s5", st_a[8:6], 2);
      chk("t5.z", z_a[8:6], 1);
    end
    clr = 4'b0100; en = '1;
    cyc();
    chk("t5.clr_s7", st_a[8:6], 0);
    chk("t5.cnt", cnt_a, 13);
    clr = '0; x = '0; y = '0;

    // 6: absorbing S9 with HOLD_CYCLES=0, then asynchronous reset mid-cycle
    x = 4'b1000; y = 4'b1000; cyc();
    x = '0; y = '0;
    cyc(100);
    chk("t6.absorb", st_b[11:9], 5);
    chk("t6.trap", trap_b[3], 1);
    #3;
    rst = 1'b1;
    model_reset();
    #1;
    chk("t6.async_state", st_b, 0);
    chk("t6.async_z", z_b, 0);
    chk("t6.async_cnt", cnt_b, 0);
    #2;
    rst = 1'b0;

    // random phase
    for (int i = 0; i < 1500; i++) begin
      en  = 4'($urandom);
      x   = 4'($urandom);
      y   = 4'($urandom);
      clr = ($urandom_range(0, 11) == 0) ? 4'($urandom) : 4'b0000;
      cyc();
    end

    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
